// File: rtl/and_cascade.sv
// N-input AND with a registered status group: y_q, zero count, lowest-zero index, edge pulses.
// Define AND_CASCADE_PIPE_EN for a two-stage version (per-GROUP partials, then combine); default is one stage.
module and_cascade #(
   parameter int N     = 8,
   parameter int GROUP = 4,
   localparam int ZW   = $clog2(N + 1),
   localparam int FW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  in,
   output logic          y,
   output logic          y_q,
   output logic [ZW-1:0] zero_cnt,
   output logic [FW-1:0] first_zero,
   output logic          fz_valid,
   output logic          rise,
   output logic          fall
);

   if (N < 1 || N > 64 || GROUP < 1 || GROUP > N) begin : g_bad_cfg
      $error("and_cascade: illegal N/GROUP combination");
   end

   assign y = &in;

   logic          y_reg_d, y_reg_q;
   logic [ZW-1:0] cnt_d, cnt_q;
   logic [FW-1:0] fz_d, fz_q;
   logic          fzv_d, fzv_q;
   logic          y_prev_d, y_prev_q;

`ifdef AND_CASCADE_PIPE_EN
   localparam int NG = (N + GROUP - 1) / GROUP;
   localparam int PW = NG * GROUP;
   localparam int CW = $clog2(GROUP + 1);
   localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;

   // Bits beyond N are padded with 1 so they neither break the AND nor count as zeros.
   logic [PW-1:0] in_pad;
   logic [NG-1:0] gand_d, gand_q;
   logic [CW-1:0] gcnt_d [NG];
   logic [CW-1:0] gcnt_q [NG];
   logic [GW-1:0] gfz_d  [NG];
   logic [GW-1:0] gfz_q  [NG];
   logic          s1_vld_q;

   always_comb begin
      in_pad         = '1;
      in_pad[N-1:0]  = in;
   end

   always_comb begin
      for (int g = 0; g < NG; g++) begin
         gand_d[g] = &in_pad[g*GROUP +: GROUP];
         gcnt_d[g] = '0;
         gfz_d[g]  = '0;
         for (int j = GROUP - 1; j >= 0; j--) begin
            if (!in_pad[g*GROUP + j]) begin
               gcnt_d[g] = gcnt_d[g] + CW'(1);
               gfz_d[g]  = GW'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gand_q   <= '0;
         s1_vld_q <= 1'b0;
         for (int g = 0; g < NG; g++) begin
            gcnt_q[g] <= '0;
            gfz_q[g]  <= '0;
         end
      end else begin
         gand_q   <= gand_d;
         s1_vld_q <= 1'b1;
         for (int g = 0; g < NG; g++) begin
            gcnt_q[g] <= gcnt_d[g];
            gfz_q[g]  <= gfz_d[g];
         end
      end
   end

   // Stage 2 holds its reset values until stage 1 has captured a real sample,
   // so y_q, zero_cnt and fz_valid stay mutually consistent right after reset.
   always_comb begin
      y_reg_d = 1'b0;
      cnt_d   = '0;
      fz_d    = '0;
      fzv_d   = 1'b0;
      if (s1_vld_q) begin
         y_reg_d = &gand_q;
         for (int g = NG - 1; g >= 0; g--) begin
            cnt_d = cnt_d + ZW'(gcnt_q[g]);
            if (!gand_q[g]) begin
               fz_d  = FW'(g * GROUP + int'(gfz_q[g]));
               fzv_d = 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      y_reg_d = &in;
      cnt_d   = '0;
      fz_d    = '0;
      fzv_d   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!in[i]) begin
            cnt_d = cnt_d + ZW'(1);
            fz_d  = FW'(i);
            fzv_d = 1'b1;
         end
      end
   end
`endif

   assign y_prev_d = y_reg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg_q  <= 1'b0;
         cnt_q    <= '0;
         fz_q     <= '0;
         fzv_q    <= 1'b0;
         y_prev_q <= 1'b0;
      end else begin
         y_reg_q  <= y_reg_d;
         cnt_q    <= cnt_d;
         fz_q     <= fz_d;
         fzv_q    <= fzv_d;
         y_prev_q <= y_prev_d;
      end
   end

   assign y_q        = y_reg_q;
   assign zero_cnt   = cnt_q;
   assign first_zero = fz_q;
   assign fz_valid   = fzv_q;
   assign rise       = y_reg_q & ~y_prev_q;
   assign fall       = ~y_reg_q & y_prev_q;

endmodule

// File: tb/tb_and_cascade.sv
// Directed bench for and_cascade (N=8, GROUP=4); follows AND_CASCADE_PIPE_EN for the expected latency.
module tb_and_cascade;

`ifdef AND_CASCADE_PIPE_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [7:0] in;
   logic       y;
   logic       y_q;
   logic [3:0] zero_cnt;
   logic [2:0] first_zero;
   logic       fz_valid;
   logic       rise;
   logic       fall;

   int n_vec;
   int n_err;

   and_cascade #(.N(8), .GROUP(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in),
      .y          (y),
      .y_q        (y_q),
      .zero_cnt   (zero_cnt),
      .first_zero (first_zero),
      .fz_valid   (fz_valid),
      .rise       (rise),
      .fall       (fall)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic e_y_q, input logic [3:0] e_cnt,
                             input logic [2:0] e_fz, input logic e_fzv);
      check({tag, ".y_q"},        y_q,        e_y_q);
      check({tag, ".zero_cnt"},   zero_cnt,   e_cnt);
      check({tag, ".first_zero"}, first_zero, e_fz);
      check({tag, ".fz_valid"},   fz_valid,   e_fzv);
   endtask

   task automatic check_edges(input string tag, input logic e_rise, input logic e_fall);
      check({tag, ".rise"}, rise, e_rise);
      check({tag, ".fall"}, fall, e_fall);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      clk_en = 1'b0;
      rst_n  = 1'b1;
      in     = 8'hFF;
      #1 rst_n = 1'b0;
      #1;
      check_regs("reset", 1'b0, 4'd0, 3'd0, 1'b0);
      check_edges("reset", 1'b0, 1'b0);

      // combinational y with the clock stopped
      in = 8'hFF; #10; check("y_ff", y, 1'b1);
      in = 8'hFE; #10; check("y_fe", y, 1'b0);
      in = 8'hBF; #10; check("y_bf", y, 1'b0);
      in = 8'h00; #10; check("y_00", y, 1'b0);

      // leave reset with all-ones input
      in     = 8'hFF;
      clk_en = 1'b1;
      #1 rst_n = 1'b1;
      for (int k = 1; k < L; k++) begin
         step();
         check_regs("ff_pre", 1'b0, 4'd0, 3'd0, 1'b0);
         check_edges("ff_pre", 1'b0, 1'b0);
      end
      step();
      check_regs("ff_lat", 1'b1, 4'd0, 3'd0, 1'b0);
      check_edges("ff_lat", 1'b1, 1'b0);
      step();
      check_regs("ff_hold", 1'b1, 4'd0, 3'd0, 1'b0);
      check_edges("ff_hold", 1'b0, 1'b0);

      // in=B4: zeros at bits 0,1,3,6
      in = 8'hB4;
      for (int k = 1; k < L; k++) begin
         step();
         check("b4_pre.y_q", y_q, 1'b1);
      end
      step();
      check_regs("b4", 1'b0, 4'd4, 3'd0, 1'b1);
      check_edges("b4", 1'b0, 1'b1);
      step();
      check_edges("b4_hold", 1'b0, 1'b0);

      in = 8'h80;
      repeat (L) step();
      check_regs("h80", 1'b0, 4'd7, 3'd0, 1'b1);
      in = 8'h7F;
      repeat (L) step();
      check_regs("h7f", 1'b0, 4'd1, 3'd7, 1'b1);
      check_edges("h7f", 1'b0, 1'b0);
      in = 8'hEF;
      repeat (L) step();
      check_regs("hef", 1'b0, 4'd1, 3'd4, 1'b1);
      in = 8'h37;
      repeat (L) step();
      check_regs("h37", 1'b0, 4'd3, 3'd3, 1'b1);

      // FF -> 00 (one cycle) -> FF
      in = 8'hFF;
      repeat (L + 2) step();
      check_regs("ff_settle", 1'b1, 4'd0, 3'd0, 1'b0);
      in = 8'h00;
      for (int k = 1; k <= L + 2; k++) begin
         step();
         if (k == 1) in = 8'hFF;
         check("tog.fall", fall, (k == L) ? 1'b1 : 1'b0);
         check("tog.rise", rise, (k == L + 1) ? 1'b1 : 1'b0);
         check("tog.y_q",  y_q,  (k == L) ? 1'b0 : 1'b1);
         check("tog.cnt",  zero_cnt, (k == L) ? 4'd8 : 4'd0);
      end

      // asynchronous reset mid-stream
      repeat (L + 1) step();
      check("pre_rst.y_q", y_q, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_regs("mid_rst", 1'b0, 4'd0, 3'd0, 1'b0);
      check_edges("mid_rst", 1'b0, 1'b0);
      check("mid_rst.y", y, 1'b1);
      step();
      check_regs("rst_held", 1'b0, 4'd0, 3'd0, 1'b0);
      rst_n = 1'b1;
      repeat (L) step();
      check_regs("post_rst", 1'b1, 4'd0, 3'd0, 1'b0);
      check_edges("post_rst", 1'b1, 1'b0);
      step();
      check_edges("post_rst_hold", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
